// File: rtl/ysyx_22040386_rf_wb_arbiter.sv
// ysyx_22040386_rf_wb_arbiter
// Write-back arbiter and scoreboard for the 32 x 64-bit integer register file.
// Shares the single write port between the ALU and LSU write-back requesters
// (round-robin), drives the port from a registered stage, and keeps one
// pending bit per register so decode can stall on an outstanding write.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/ready/waddr/wdata   ALU write-back request
//   lsu_valid/ready/waddr/wdata   LSU write-back request
//   sb_set, sb_addr               mark a destination register pending
//   sb_flush                      clear every pending bit
//   raddr1/2 -> busy1/2           operand has an outstanding write (comb.)
//   rf_wen/waddr/wdata            registered register-file write port
//   fwd1/2_valid, fwd1/2_data     bypass of the registered write (optional)
//
// Build option: define YSYX_22040386_WB_BYPASS_EN to add the fwd ports and let a
// bypass hit mask busy in the write cycle.
module ysyx_22040386_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_addr,
  input  logic                  sb_flush,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
`ifdef YSYX_22040386_WB_BYPASS_EN
  output logic                  fwd1_valid,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} gnt_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  gnt_e            last_grant;
  wb_req_t         gnt_req;
  logic            grant;
  logic [NREG-1:0] pend, pend_nxt;

  // ---------------- arbitration ----------------
  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || last_grant == GNT_LSU);
    lsu_ready = lsu_valid && (!alu_valid || last_grant == GNT_ALU);
    grant     = alu_ready || lsu_ready;
    gnt_req   = alu_ready ? wb_req_t'{alu_waddr, alu_wdata}
                          : wb_req_t'{lsu_waddr, lsu_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= GNT_LSU;
    else if (alu_ready) last_grant <= GNT_ALU;
    else if (lsu_ready) last_grant <= GNT_LSU;
  end

  // ---------------- registered write stage ----------------
  // A grant to x0 completes the handshake and still moves addr/data, but never
  // raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= grant && (gnt_req.addr != '0);
      if (grant) begin
        rf_waddr <= gnt_req.addr;
        rf_wdata <= gnt_req.data;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Set is applied after clear so a newly issued instruction keeps its bit
  // when an older write to the same register commits in the same cycle.
  always_comb begin
    pend_nxt = pend;
    if (rf_wen) pend_nxt[rf_waddr] = 1'b0;
    if (sb_set) pend_nxt[sb_addr]  = 1'b1;
    pend_nxt[0] = 1'b0;
    if (sb_flush) pend_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

`ifdef YSYX_22040386_WB_BYPASS_EN
  // The register file only sees the registered write at the end of this
  // cycle, so forward it now and drop the stall one cycle early.
  always_comb begin
    fwd1_valid = rf_wen && (rf_waddr == raddr1) && (raddr1 != '0);
    fwd2_valid = rf_wen && (rf_waddr == raddr2) && (raddr2 != '0);
    fwd1_data  = rf_wdata;
    fwd2_data  = rf_wdata;
    busy1      = pend[raddr1] && !fwd1_valid;
    busy2      = pend[raddr2] && !fwd2_valid;
  end
`else
  always_comb begin
    busy1 = pend[raddr1];
    busy2 = pend[raddr2];
  end
`endif

endmodule
